// File: rtl/alu_seq.sv
// Sequential MU0-successor ALU: registered CARRY/ZERO/NEG flags, multi-bit shifts and an
// optional shift-add multiplier behind a start/busy/done handshake. Optional: ALU_SEQ_MUL_EN.
module alu_seq #(
    parameter int WIDTH   = 16,
    parameter int SHAMT_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [2:0]         op,
    input  logic [1:0]         cin_sel,
    input  logic               cw,
    input  logic [WIDTH-1:0]   rddata,
    input  logic [WIDTH-1:0]   rsdata,
    input  logic [SHAMT_W-1:0] shamt,
    output logic               busy,
    output logic               done,
    output logic               wen,
    output logic [WIDTH-1:0]   result,
    output logic               carry,
    output logic               zero,
    output logic               neg
);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_MOV = 3'b010;
    localparam logic [2:0] OP_XSR = 3'b011;
    localparam logic [2:0] OP_LSL = 3'b100;
    localparam logic [2:0] OP_LSR = 3'b101;
    localparam logic [2:0] OP_MUL = 3'b110;

    // counter must hold both the largest shift count and the WIDTH multiply steps
    localparam int CNT_W = ($clog2(WIDTH + 1) > SHAMT_W) ? $clog2(WIDTH + 1) : SHAMT_W;
    localparam logic [CNT_W-1:0] CNT_LAST = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_FIN  = 2'b10
    } state_t;

    state_t             state_r, state_next_s;
    logic               busy_r, done_r, wen_r, carry_r, zero_r, neg_r;
    logic [WIDTH-1:0]   result_r;
    logic [2:0]         op_r;
    logic               cw_r;
    logic [WIDTH-1:0]   b_r;
    logic [CNT_W-1:0]   cnt_r;
`ifdef ALU_SEQ_MUL_EN
    logic [WIDTH-1:0]   a_r;
    logic [WIDTH-1:0]   hi_r;
    logic [WIDTH-1:0]   step_hi_s;
    logic [WIDTH:0]     add_s;
`endif

    logic               cin_s;
    logic [WIDTH:0]     sum_s;
    logic [WIDTH-1:0]   single_r_s;
    logic               single_c_s, single_wen_s, multi_s;
    logic [WIDTH-1:0]   step_b_s;
    logic               step_c_s;
    logic               fin_s, fin_c_s, fin_wen_s, fin_cw_s;
    logic [WIDTH-1:0]   fin_r_s;

    assign busy   = busy_r;
    assign done   = done_r;
    assign wen    = wen_r;
    assign result = result_r;
    assign carry  = carry_r;
    assign zero   = zero_r;
    assign neg    = neg_r;

    // Single-cycle result from the live inputs, used on the start edge
    always_comb begin
        cin_s        = 1'b0;
        sum_s        = {(WIDTH+1){1'b0}};
        single_r_s   = {WIDTH{1'b0}};
        single_c_s   = 1'b0;
        single_wen_s = 1'b1;
        multi_s      = 1'b0;
        case (cin_sel)
            2'b00:   cin_s = 1'b0;
            2'b01:   cin_s = 1'b1;
            2'b10:   cin_s = carry_r;
            2'b11:   cin_s = rsdata[WIDTH-1];
            default: cin_s = 1'b0;
        endcase
        case (op)
            OP_ADD: begin
                sum_s      = {1'b0, rddata} + {1'b0, rsdata} + {{WIDTH{1'b0}}, cin_s};
                single_r_s = sum_s[WIDTH-1:0];
                single_c_s = sum_s[WIDTH];
            end
            OP_SUB: begin
                sum_s      = {1'b0, rddata} + {1'b0, ~rsdata} + {{WIDTH{1'b0}}, cin_s};
                single_r_s = sum_s[WIDTH-1:0];
                single_c_s = sum_s[WIDTH];
            end
            OP_MOV: begin
                sum_s      = {1'b0, rsdata} + {{WIDTH{1'b0}}, cin_s};
                single_r_s = sum_s[WIDTH-1:0];
                single_c_s = sum_s[WIDTH];
            end
            OP_XSR: begin
                single_r_s = {cin_s, rsdata[WIDTH-1:1]};
                single_c_s = rsdata[0];
            end
            OP_LSL, OP_LSR: begin
                // a zero-length shift passes B through and leaves carry as it was
                single_r_s = rsdata;
                single_c_s = carry_r;
                multi_s    = (shamt != {SHAMT_W{1'b0}});
            end
`ifdef ALU_SEQ_MUL_EN
            OP_MUL: begin
                multi_s = 1'b1;
            end
`endif
            default: begin
                single_r_s   = {WIDTH{1'b0}};
                single_c_s   = 1'b0;
                single_wen_s = 1'b0;
            end
        endcase
    end

    // One RUN step: a single-bit shift or one shift-add partial product
    always_comb begin
        step_b_s = b_r;
        step_c_s = 1'b0;
`ifdef ALU_SEQ_MUL_EN
        step_hi_s = hi_r;
        add_s     = {1'b0, hi_r} + (b_r[0] ? {1'b0, a_r} : {(WIDTH+1){1'b0}});
`endif
        case (op_r)
            OP_LSL: begin
                step_b_s = {b_r[WIDTH-2:0], 1'b0};
                step_c_s = b_r[WIDTH-1];
            end
            OP_LSR: begin
                step_b_s = {1'b0, b_r[WIDTH-1:1]};
                step_c_s = b_r[0];
            end
`ifdef ALU_SEQ_MUL_EN
            OP_MUL: begin
                // product high half accumulates in hi_r, low half shifts into b_r
                step_hi_s = add_s[WIDTH:1];
                step_b_s  = {add_s[0], b_r[WIDTH-1:1]};
                step_c_s  = |add_s[WIDTH:1];
            end
`endif
            default: begin
                step_b_s = b_r;
                step_c_s = 1'b0;
            end
        endcase
    end

    // Next-state and write-back selection
    always_comb begin
        state_next_s = state_r;
        fin_s        = 1'b0;
        fin_r_s      = {WIDTH{1'b0}};
        fin_c_s      = 1'b0;
        fin_wen_s    = 1'b0;
        fin_cw_s     = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (start) begin
                    if (multi_s) begin
                        state_next_s = S_RUN;
                    end else begin
                        state_next_s = S_FIN;
                        fin_s        = 1'b1;
                        fin_r_s      = single_r_s;
                        fin_c_s      = single_c_s;
                        fin_wen_s    = single_wen_s;
                        fin_cw_s     = cw;
                    end
                end else begin
                    state_next_s = S_IDLE;
                end
            end
            S_RUN: begin
                if (cnt_r == CNT_LAST) begin
                    state_next_s = S_FIN;
                    fin_s        = 1'b1;
                    fin_r_s      = step_b_s;
                    fin_c_s      = step_c_s;
                    fin_wen_s    = 1'b1;
                    fin_cw_s     = cw_r;
                end else begin
                    state_next_s = S_RUN;
                end
            end
            S_FIN:   state_next_s = S_IDLE;
            default: state_next_s = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Handshake outputs, result and flags
    always_ff @(posedge clk) begin
        if (reset) begin
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            wen_r    <= 1'b0;
            result_r <= {WIDTH{1'b0}};
            carry_r  <= 1'b0;
            zero_r   <= 1'b0;
            neg_r    <= 1'b0;
        end else begin
            busy_r <= (state_next_s != S_IDLE);
            done_r <= fin_s;
            wen_r  <= fin_s & fin_wen_s;
            if (fin_s) begin
                result_r <= fin_r_s;
                zero_r   <= (fin_r_s == {WIDTH{1'b0}});
                neg_r    <= fin_r_s[WIDTH-1];
                if (fin_cw_s) begin
                    carry_r <= fin_c_s;
                end
            end
        end
    end

    // Operand capture on the start edge and iteration state
    always_ff @(posedge clk) begin
        if (reset) begin
            op_r  <= 3'b000;
            cw_r  <= 1'b0;
            b_r   <= {WIDTH{1'b0}};
            cnt_r <= {CNT_W{1'b0}};
`ifdef ALU_SEQ_MUL_EN
            a_r   <= {WIDTH{1'b0}};
            hi_r  <= {WIDTH{1'b0}};
`endif
        end else if ((state_r == S_IDLE) && start) begin
            op_r  <= op;
            cw_r  <= cw;
            b_r   <= rsdata;
            cnt_r <= (op == OP_MUL) ? CNT_W'(WIDTH) : CNT_W'(shamt);
`ifdef ALU_SEQ_MUL_EN
            a_r   <= rddata;
            hi_r  <= {WIDTH{1'b0}};
`endif
        end else if (state_r == S_RUN) begin
            b_r   <= step_b_s;
            cnt_r <= cnt_r - CNT_LAST;
`ifdef ALU_SEQ_MUL_EN
            hi_r  <= step_hi_s;
`endif
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq (WIDTH=16): directed vector table, multi-cycle corner
// sequences and random operations against a plain-arithmetic reference model.
module tb_alu_seq;

    logic        clk = 1'b0;
    logic        reset, start, cw;
    logic [2:0]  op;
    logic [1:0]  cin_sel;
    logic [15:0] rddata, rsdata;
    logic [3:0]  shamt;
    logic        busy, done, wen, carry, zero, neg;
    logic [15:0] result;

    int nerr = 0;
    int nchk = 0;
    logic carry_m = 1'b0;

    alu_seq #(.WIDTH(16), .SHAMT_W(4)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .cin_sel(cin_sel), .cw(cw),
        .rddata(rddata), .rsdata(rsdata), .shamt(shamt), .busy(busy), .done(done),
        .wen(wen), .result(result), .carry(carry), .zero(zero), .neg(neg)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [1:0]  cs;
        logic        cw;
        logic [15:0] a;
        logic [15:0] b;
        logic [3:0]  sh;
        logic [15:0] er;
        logic        ec;
        logic        ew;
        int          el;
    } vec_t;

    vec_t tbl[13];

    task automatic chk(input string tag, input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s.%s: got %0h expected %0h", tag, name, act, exp);
        end
    endtask

    // Reference model: expected result, carry-out, write enable and latency
    task automatic ref_op(input logic [2:0] o, input logic [1:0] cs, input logic [15:0] a,
                          input logic [15:0] b, input logic [3:0] sh, input logic cflag,
                          output logic [15:0] r, output logic c, output logic w,
                          output int lat);
        logic        cin;
        logic [16:0] t;
        logic [31:0] p;
        cin = (cs == 2'd0) ? 1'b0 : (cs == 2'd1) ? 1'b1 : (cs == 2'd2) ? cflag : b[15];
        w = 1'b1;
        lat = 1;
        r = 16'h0;
        c = 1'b0;
        case (o)
            3'd0: begin t = 17'(a) + 17'(b) + 17'(cin); r = t[15:0]; c = t[16]; end
            3'd1: begin t = 17'(a) + 17'(16'hFFFF - b) + 17'(cin); r = t[15:0]; c = t[16]; end
            3'd2: begin t = 17'(b) + 17'(cin); r = t[15:0]; c = t[16]; end
            3'd3: begin r = (b >> 1) | (16'(cin) << 15); c = b[0]; end
            3'd4, 3'd5: begin
                if (sh == 4'd0) begin
                    r = b;
                    c = cflag;
                end else if (o == 3'd4) begin
                    p = 32'(b) << sh;
                    r = p[15:0];
                    c = p[16];
                    lat = int'(sh) + 1;
                end else begin
                    r = b >> sh;
                    p = 32'(b) >> (int'(sh) - 1);
                    c = p[0];
                    lat = int'(sh) + 1;
                end
            end
            3'd6: begin
`ifdef ALU_SEQ_MUL_EN
                p = 32'(a) * 32'(b);
                r = p[15:0];
                c = (p[31:16] != 16'h0);
                lat = 17;
`else
                w = 1'b0;
`endif
            end
            default: begin w = 1'b0; end
        endcase
    endtask

    // Issue one operation, scramble inputs after the start edge, wait for done and compare
    task automatic run_op(input string tag, input logic [2:0] o, input logic [1:0] cs,
                          input logic cwv, input logic [15:0] a, input logic [15:0] b,
                          input logic [3:0] sh, input logic [15:0] er, input logic ec,
                          input logic ew, input int el);
        int lat;
        @(negedge clk);
        op = o; cin_sel = cs; cw = cwv; rddata = a; rsdata = b; shamt = sh; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        op = 3'($urandom); cin_sel = 2'($urandom); cw = 1'($urandom);
        rddata = 16'($urandom); rsdata = 16'($urandom); shamt = 4'($urandom);
        lat = 1;
        while (done !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk(tag, "latency", lat, el);
        chk(tag, "done", {31'b0, done}, 32'd1);
        chk(tag, "busy", {31'b0, busy}, 32'd1);
        chk(tag, "result", {16'b0, result}, {16'b0, er});
        chk(tag, "carry", {31'b0, carry}, {31'b0, ec});
        chk(tag, "zero", {31'b0, zero}, {31'b0, (er == 16'h0)});
        chk(tag, "neg", {31'b0, neg}, {31'b0, er[15]});
        chk(tag, "wen", {31'b0, wen}, {31'b0, ew});
        carry_m = ec;
    endtask

    initial begin
        logic [15:0] r, dres;
        logic        c, w;
        int          lat, ndone, dlat;

        tbl[0]  = '{3'd0, 2'd0, 1'b1, 16'hFFFF, 16'h0001, 4'd0, 16'h0000, 1'b1, 1'b1, 1};
        tbl[1]  = '{3'd1, 2'd1, 1'b1, 16'h0005, 16'h0003, 4'd0, 16'h0002, 1'b1, 1'b1, 1};
        tbl[2]  = '{3'd0, 2'd0, 1'b1, 16'h0001, 16'h0001, 4'd0, 16'h0002, 1'b0, 1'b1, 1};
        tbl[3]  = '{3'd1, 2'd1, 1'b0, 16'h0005, 16'h0003, 4'd0, 16'h0002, 1'b0, 1'b1, 1};
        tbl[4]  = '{3'd2, 2'd1, 1'b1, 16'hAAAA, 16'h7FFF, 4'd0, 16'h8000, 1'b0, 1'b1, 1};
        tbl[5]  = '{3'd3, 2'd1, 1'b1, 16'hAAAA, 16'h0013, 4'd0, 16'h8009, 1'b1, 1'b1, 1};
        tbl[6]  = '{3'd0, 2'd2, 1'b1, 16'h1234, 16'h0001, 4'd0, 16'h1236, 1'b0, 1'b1, 1};
        tbl[7]  = '{3'd5, 2'd0, 1'b1, 16'hAAAA, 16'h0013, 4'd2, 16'h0004, 1'b1, 1'b1, 3};
        tbl[8]  = '{3'd4, 2'd0, 1'b1, 16'hAAAA, 16'h8001, 4'd0, 16'h8001, 1'b1, 1'b1, 1};
        tbl[9]  = '{3'd7, 2'd0, 1'b1, 16'h1111, 16'h2222, 4'd3, 16'h0000, 1'b0, 1'b0, 1};
`ifdef ALU_SEQ_MUL_EN
        tbl[10] = '{3'd6, 2'd0, 1'b1, 16'h012C, 16'h012C, 4'd0, 16'h5F90, 1'b1, 1'b1, 17};
`else
        tbl[10] = '{3'd6, 2'd0, 1'b1, 16'h012C, 16'h012C, 4'd0, 16'h0000, 1'b0, 1'b0, 1};
`endif
        tbl[11] = '{3'd2, 2'd3, 1'b1, 16'hAAAA, 16'h0000, 4'd0, 16'h0000, 1'b0, 1'b1, 1};
        tbl[12] = '{3'd4, 2'd0, 1'b1, 16'hAAAA, 16'h8001, 4'd15, 16'h8000, 1'b0, 1'b1, 16};

        reset = 1'b1; start = 1'b0; op = 3'd0; cin_sel = 2'd0; cw = 1'b0;
        rddata = 16'h0; rsdata = 16'h0; shamt = 4'd0;
        repeat (3) @(negedge clk);
        chk("reset", "outs", {25'b0, busy, done, wen, carry, zero, neg, 1'b0},
            32'd0);
        chk("reset", "result", {16'b0, result}, 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 13; i++) begin
            run_op($sformatf("vec%0d", i), tbl[i].op, tbl[i].cs, tbl[i].cw, tbl[i].a,
                   tbl[i].b, tbl[i].sh, tbl[i].er, tbl[i].ec, tbl[i].ew, tbl[i].el);
        end

        // start pulsed mid-shift must be ignored: one done, with the shift result
        ref_op(3'd4, 2'd0, 16'h0000, 16'h0103, 4'd7, carry_m, r, c, w, lat);
        @(negedge clk);
        op = 3'd4; cin_sel = 2'd0; cw = 1'b1; rddata = 16'h0; rsdata = 16'h0103;
        shamt = 4'd7; start = 1'b1;
        ndone = 0; dlat = 0; dres = 16'h0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            start = (i == 2);
            op = (i == 2) ? 3'd0 : 3'd4;
            rsdata = (i == 2) ? 16'h0F0F : 16'h0103;
            if (done === 1'b1) begin
                ndone++;
                dlat = i;
                dres = result;
            end
        end
        chk("busy_start", "done_count", ndone, 1);
        chk("busy_start", "latency", dlat, lat);
        chk("busy_start", "result", {16'b0, dres}, {16'b0, r});
        chk("busy_start", "carry", {31'b0, carry}, {31'b0, c});
        carry_m = c;

        // reset in the middle of a multi-cycle op clears everything, no done follows
        run_op("pre_reset", 3'd0, 2'd0, 1'b1, 16'hFFFF, 16'hFFFF, 4'd0, 16'hFFFE, 1'b1,
               1'b1, 1);
        @(negedge clk);
`ifdef ALU_SEQ_MUL_EN
        op = 3'd6; shamt = 4'd0;
`else
        op = 3'd4; shamt = 4'd15;
`endif
        rddata = 16'h012C; rsdata = 16'h012C; cw = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("mid_reset", "busy_before", {31'b0, busy}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("mid_reset", "outs", {26'b0, busy, done, wen, carry, zero, neg}, 32'd0);
        chk("mid_reset", "result", {16'b0, result}, 32'd0);
        ndone = 0;
        repeat (25) begin
            @(negedge clk);
            if (done !== 1'b0) ndone++;
        end
        chk("mid_reset", "no_done", ndone, 0);
        carry_m = 1'b0;

        for (int i = 0; i < 200; i++) begin
            logic [2:0]  ro;
            logic [1:0]  rc;
            logic        rw;
            logic [15:0] ra, rb;
            logic [3:0]  rs;
            ro = 3'($urandom_range(0, 7));
            rc = 2'($urandom);
            rw = 1'($urandom);
            ra = 16'($urandom);
            rb = (i % 10 == 0) ? 16'h0 : 16'($urandom);
            rs = 4'($urandom);
            ref_op(ro, rc, ra, rb, rs, carry_m, r, c, w, lat);
            run_op($sformatf("rnd%0d", i), ro, rc, rw, ra, rb, rs, r,
                   rw ? c : carry_m, w, lat);
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
